// File: rtl/fp_add_pkg.sv
// Shared types and constants for the two-requester FP adder front end.
// The adder datapath lives outside; only its width and default depth are fixed here.
package fp_add_pkg;

  localparam int FP_WIDTH       = 32;
  localparam int STAGES_DEFAULT = 4;

  typedef logic [FP_WIDTH-1:0] fp_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and only
// moves when a grant is actually issued.
module rr_arb2
  import fp_add_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       grant_any,
  output req_id_e    grant_idx
);

  req_id_e last_q;

  always_comb begin
    grant = '0;
    if (en) begin
      if (req == 2'b11) grant[other_req(last_q)] = 1'b1;
      else              grant = req;
    end
  end

  assign grant_any = |grant;
  assign grant_idx = grant[1] ? REQ1 : REQ0;

  // Reset as if requester 1 won last, so requester 0 takes the first contended slot.
  always_ff @(posedge clk) begin
    if (rst)            last_q <= REQ1;
    else if (grant_any) last_q <= grant_idx;
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined FP adder between two requesters; tracks ownership of each
// in-flight op and stalls the whole pipe when the owner of the last stage backpressures.
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [FP_WIDTH-1:0] req0_a,
  input  logic [FP_WIDTH-1:0] req0_b,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [FP_WIDTH-1:0] req1_a,
  input  logic [FP_WIDTH-1:0] req1_b,
  output logic                req1_ready,
  output logic                pipe_en,
  output logic [FP_WIDTH-1:0] pipe_a,
  output logic [FP_WIDTH-1:0] pipe_b,
  input  logic [FP_WIDTH-1:0] pipe_result,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [FP_WIDTH-1:0] rsp0_data,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [FP_WIDTH-1:0] rsp1_data,
  output logic                busy
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] t;
  logic [1:0]        rsp_ready;
  logic [1:0]        grant;
  logic              grant_any;
  req_id_e           grant_idx;
  logic              owner;
  logic              last_vld;

  assign owner     = t[STAGES-1];
  assign last_vld  = v[STAGES-1];
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Only the owner of the head op can hold the pipe; rst forces it open.
  assign pipe_en = rst | ~last_vld | rsp_ready[owner];

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (pipe_en & ~rst),
    .req       ({req1_valid, req0_valid}),
    .grant     (grant),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign pipe_a     = grant[1] ? req1_a : req0_a;
  assign pipe_b     = grant[1] ? req1_b : req0_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      t <= '0;
    end else if (pipe_en) begin
      v <= {v[STAGES-2:0], grant_any};
      t <= {t[STAGES-2:0], logic'(grant_idx)};
    end
  end

  assign rsp0_valid = ~rst & last_vld & ~owner;
  assign rsp1_valid = ~rst & last_vld &  owner;
  assign rsp0_data  = pipe_result;
  assign rsp1_data  = pipe_result;
  assign busy       = ~rst & (|v);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: integer-valued float operands, a stub pipelined adder
// and a grant-order scoreboard with a round-robin reference model.
module tb_fp_add_arbiter;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        pipe_en;
  logic [31:0] pipe_a, pipe_b, pipe_result;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        busy;

  int req0_ia, req0_ib, req1_ia, req1_ib;
  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  int last_g  = 1;

  typedef struct {
    int          tag;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fp_add_arbiter #(.STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .pipe_en(pipe_en), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_result(pipe_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  function automatic logic [31:0] itof(input int n);
    int m;
    logic [7:0]  e;
    logic [22:0] f;
    if (n <= 0) return 32'h0;
    m = 0;
    for (int i = 0; i < 24; i++) if (((n >> i) & 1) != 0) m = i;
    e = 8'(127 + m);
    f = 23'(n << (23 - m));
    return {1'b0, e, f};
  endfunction

  function automatic int ftoi(input logic [31:0] x);
    int e;
    int mant;
    e = int'(x[30:23]);
    if (e == 0 || e > 150) return 0;
    mant = int'({1'b1, x[22:0]});
    return mant >> (150 - e);
  endfunction

  // Stub adder: S enabled register stages, output aligned with the last tag stage.
  logic [31:0] add_q [S];
  always @(posedge clk) begin
    if (pipe_en) begin
      for (int i = S - 1; i > 0; i--) add_q[i] <= add_q[i-1];
      add_q[0] <= itof(ftoi(pipe_a) + ftoi(pipe_b));
    end
  end
  assign pipe_result = add_q[S-1];

  // Reference: round-robin grant prediction plus in-order per-tag result queue.
  always @(negedge clk) begin
    logic g0, g1, pe;
    exp_t e;
    if (rst) begin
      sb.delete();
      last_g = 1;
    end else begin
      pe = !((rsp0_valid && !rsp0_ready) || (rsp1_valid && !rsp1_ready));
      n_tests++;
      if (pipe_en !== pe) begin
        n_fail++; $display("FAIL pipe_en: got %b want %b", pipe_en, pe);
      end
      g0 = pipe_en && req0_valid && (!req1_valid || last_g == 1);
      g1 = pipe_en && req1_valid && !g0;
      n_tests++;
      if (req0_ready !== g0 || req1_ready !== g1) begin
        n_fail++; $display("FAIL grant: got %b%b want %b%b", req1_ready, req0_ready, g1, g0);
      end
      if (g0) begin sb.push_back('{0, itof(req0_ia + req0_ib)}); last_g = 0; end
      if (g1) begin sb.push_back('{1, itof(req1_ia + req1_ib)}); last_g = 1; end
      if (rsp0_valid && rsp1_valid) begin
        n_tests++; n_fail++; $display("FAIL rsp_exclusive: both rsp valids high");
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rsp_unexpected: rsp with no op outstanding");
        end else begin
          e = sb.pop_front();
          n_rsp++;
          if ((rsp1_valid ? 1 : 0) != e.tag || (rsp1_valid ? rsp1_data : rsp0_data) !== e.data) begin
            n_fail++;
            $display("FAIL rsp_order: got tag %0d data %h want tag %0d data %h",
                     rsp1_valid ? 1 : 0, rsp1_valid ? rsp1_data : rsp0_data, e.tag, e.data);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set0(input int a, input int b);
    req0_ia = a; req0_ib = b; req0_a = itof(a); req0_b = itof(b);
  endtask

  task automatic set1(input int a, input int b);
    req1_ia = a; req1_ib = b; req1_a = itof(a); req1_b = itof(b);
  endtask

  task automatic rnd_ops();
    set0(int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));
    set1(int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));
  endtask

  task automatic pulse_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (n) cyc();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL drain: %0d ops never returned, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    rnd_ops();
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (req0_ready !== 0 || req1_ready !== 0 || rsp0_valid !== 0 || rsp1_valid !== 0 ||
          pipe_en !== 1 || busy !== 0) begin
        n_fail++;
        $display("FAIL reset_outputs: rdy %b%b rsp %b%b en %b busy %b want 00 00 1 0",
                 req1_ready, req0_ready, rsp1_valid, rsp0_valid, pipe_en, busy);
      end
      cyc();
    end
    rst = 1'b0; req0_valid = 0; req1_valid = 0;
    cyc();
  endtask

  task automatic test_single();
    set0(1, 2); req0_valid = 1;
    @(negedge clk);
    n_tests++;
    if (req0_ready !== 1 || pipe_a !== 32'h3F800000 || pipe_b !== 32'h40000000) begin
      n_fail++; $display("FAIL single_accept: ready %b a %h b %h", req0_ready, pipe_a, pipe_b);
    end
    cyc(); req0_valid = 0;
    for (int k = 1; k <= S; k++) begin
      @(negedge clk);
      n_tests++;
      if (rsp0_valid !== (k == S) || busy !== 1) begin
        n_fail++; $display("FAIL single_latency: cyc %0d rsp0_valid %b busy %b", k, rsp0_valid, busy);
      end
      if (k == S) begin
        n_tests++;
        if (rsp0_data !== 32'h40400000) begin
          n_fail++; $display("FAIL single_data: got %h want 40400000", rsp0_data);
        end
      end
      cyc();
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 0) begin
      n_fail++; $display("FAIL single_idle: busy %b want 0", busy);
    end
    cyc();
  endtask

  task automatic test_contention();
    pulse_reset();
    rnd_ops(); req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL contention_rr: slot %0d rdy %b%b", i, req1_ready, req0_ready);
      end
      cyc(); rnd_ops();
    end
    drain(S + 4);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int first_sum, rsp_base;
    rsp0_ready = 1; req0_valid = 1;
    set0(int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));
    first_sum = req0_ia + req0_ib;
    rsp_base = n_rsp;
    repeat (S) begin
      cyc(); set0(int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));
    end
    rsp0_ready = 0;
    @(negedge clk);
    held = rsp0_data;
    n_tests++;
    if (held !== itof(first_sum)) begin
      n_fail++; $display("FAIL bp_head: got %h want %h", held, itof(first_sum));
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (pipe_en !== 0 || req0_ready !== 0 || rsp0_valid !== 1 || rsp0_data !== held || busy !== 1) begin
        n_fail++;
        $display("FAIL bp_stall: cyc %0d en %b rdy %b vld %b data %h want 0 0 1 %h",
                 i, pipe_en, req0_ready, rsp0_valid, rsp0_data, held);
      end
      cyc();
    end
    rsp0_ready = 1; req0_valid = 0;
    repeat (S + 2) cyc();
    n_tests++;
    if (n_rsp - rsp_base != S) begin
      n_fail++; $display("FAIL bp_count: got %0d results want %0d", n_rsp - rsp_base, S);
    end
    drain(2);
  endtask

  task automatic test_drain_issue();
    int w;
    rsp1_ready = 0; req1_valid = 1;
    set1(int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));
    cyc(); req1_valid = 0;
    w = 0;
    while (!rsp1_valid && w < 10) begin cyc(); w++; end
    n_tests++;
    if (rsp1_valid !== 1) begin
      n_fail++; $display("FAIL di_timeout: rsp1_valid %b want 1", rsp1_valid);
    end
    set1(int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));
    req1_valid = 1;
    @(negedge clk);
    n_tests++;
    if (req1_ready !== 0) begin
      n_fail++; $display("FAIL di_stalled: req1_ready %b want 0", req1_ready);
    end
    cyc(); rsp1_ready = 1;
    @(negedge clk);
    n_tests++;
    if (req1_ready !== 1 || rsp1_valid !== 1 || pipe_en !== 1) begin
      n_fail++; $display("FAIL di_both: rdy %b vld %b en %b want 1 1 1", req1_ready, rsp1_valid, pipe_en);
    end
    cyc(); req1_valid = 0;
    @(negedge clk);
    n_tests++;
    if (sb.size() != 1 || busy !== 1) begin
      n_fail++; $display("FAIL di_occupancy: inflight %0d busy %b want 1 1", sb.size(), busy);
    end
    drain(S + 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rnd_ops();
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    drain(S + 30);
  endtask

  task automatic test_reset_mid();
    rsp0_ready = 1; rsp1_ready = 1; req0_valid = 1;
    repeat (3) begin
      set0(int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));
      cyc();
    end
    req0_valid = 0;
    pulse_reset();
    @(negedge clk);
    n_tests++;
    if (busy !== 0) begin
      n_fail++; $display("FAIL rm_busy: busy %b want 0", busy);
    end
    for (int i = 0; i < S + 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (rsp0_valid !== 0 || rsp1_valid !== 0) begin
        n_fail++; $display("FAIL rm_ghost: cyc %0d rsp %b%b want 00", i, rsp1_valid, rsp0_valid);
      end
      cyc();
    end
    rnd_ops(); req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    n_tests++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      n_fail++; $display("FAIL rm_first_grant: rdy %b%b want 01", req1_ready, req0_ready);
    end
    cyc();
    drain(S + 4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    set0(1, 1); set1(1, 1);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_drain_issue();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 SHALL have parameter STAGES, default 4: number of enabled register stages in the shared pipelined FP adder (2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester k offers an operand pair.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  IEEE-754 single operands.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  requester k's pair accepted this cycle.
REQ-007 SHALL have port pipe_en  output  1  common enable for every adder stage buffer.
REQ-008 SHALL have ports pipe_a, pipe_b  output  32  operands muxed to adder stage 0.
REQ-009 SHALL have port pipe_result  input  32  adder last-stage output, aligned with tag stage STAGES-1.
REQ-010 SHALL have ports rsp0_valid/rsp1_valid  output  1  result for requester k present.
REQ-011 SHALL have ports rsp0_ready/rsp1_ready  input  1  requester k consumes result.
REQ-012 SHALL have ports rsp0_data/rsp1_data  output  32  both driven from pipe_result.
REQ-013 SHALL have port busy  output  1  any stage occupied.

Function
REQ-014 SHALL keep a valid shift register v[STAGES-1:0] and owner-tag register t[STAGES-1:0], shifting one position per cycle only when pipe_en=1.
REQ-015 SHALL compute pipe_en = !v[STAGES-1] | rsp_ready[t[STAGES-1]] (combinational); pipe_en=0 freezes all stages, whole pipeline stalls.
REQ-016 SHALL assert rspk_valid = v[STAGES-1] & (t[STAGES-1]==k); never both rsp valids together.
REQ-017 SHALL grant at most one requester per cycle and only when pipe_en=1; reqk_ready = grant_k; no ready while stalled.
REQ-018 SHALL arbitrate round-robin: one requester valid -> grant it; both valid -> grant the one not granted last; pointer updates only on a grant.
REQ-019 SHALL drive pipe_a/pipe_b from the granted requester, from requester 0 when none granted.
REQ-020 SHALL, on an enabled edge, load v[0]=grant_any and t[0]=granted index; idle cycles insert bubbles (v[0]=0).
REQ-021 SHALL give latency STAGES-1 cycles from accept edge to rspk_valid when unstalled; throughput one op/cycle.
REQ-022 SHALL, when last stage drains and a new grant occur in the same cycle, perform both (no bubble penalty).
REQ-023 SHALL hold rspk_valid and rspk_data stable while stalled until consumed.
REQ-024 SHALL drive busy = |v.
REQ-025 SHALL ignore rsp_ready of the non-owning requester.

Reset
REQ-026 SHALL on rst=1 clear v, clear t, set round-robin pointer so requester 0 wins the first contended grant.
REQ-027 SHALL during rst hold reqk_ready=0, rspk_valid=0, pipe_en=1, busy=0.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no rsp_valid for them afterwards.

Structure
REQ-029 SHALL place FP_WIDTH=32 and the default STAGES value in shared package fp_add_pkg.
REQ-030 SHALL implement the arbiter as sub-module rr_arb2 (2 requests, enable, grant, pointer); tag/valid pipeline stays in the top level.

Verification
REQ-031 Single op: req0_valid with a=3F800000, b=40000000, STAGES=4 -> req0_ready same cycle, rsp0_valid 3 cycles later, rsp0_data=40400000.
REQ-032 Contention: both valid 6 cycles -> grants alternate 0,1,0,1,0,1; responses return in same order and tags.
REQ-033 Backpressure: rsp0_ready=0 for 5 cycles with full pipe -> pipe_en=0, no readies, data held; release -> drain one/cycle, no loss or duplication.
REQ-034 Drain+issue: last stage consumed while req1 valid -> both in one cycle, occupancy unchanged.
REQ-035 Reset mid-flight: rst with 3 ops in flight -> busy=0 next cycle, no rsp_valid afterwards; first contended grant goes to requester 0.
